tone_sequencer: RTL and testbench

// - Plays a programmable note table by driving the tonediv input of the Wavegen

---
 rtl/tone_pkg.sv | 16 +
 rtl/tick_prescaler.sv | 26 ++
 rtl/tone_sequencer.sv | 172 +++++++++++++++++
 tb/tb_tone_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared types and constants for the tone sequencer and its prescaler.
package tone_pkg;

    localparam int TONEDIV_W = 11;
    localparam logic [TONEDIV_W-1:0] REST_DIV = '0;
    localparam int END_DUR = 0;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PLAY,
        GAP,
        DONE
    } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks;
// clr holds the count at zero so the first tick after release is a full period.
module tick_prescaler #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = !clr && (cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// Walks a programmable note table, driving Wavegen's tonediv/tone_en with a
// silent gap after every note, plus start/stop, looping and end-of-song marker.
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int NOTES     = 16,
    parameter int DUR_W     = 8,
    parameter int TICK_DIV  = 50000,
    parameter int GAP_TICKS = 1,
    localparam int IDX_W    = $clog2(NOTES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop_en,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_addr,
    input  logic [TONEDIV_W-1:0] wr_tonediv,
    input  logic [DUR_W-1:0]     wr_dur,
    output logic [TONEDIV_W-1:0] tonediv,
    output logic                 tone_en,
    output logic                 busy,
    output logic                 done,
    output logic [IDX_W-1:0]     note_idx
);

    localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam int ENT_W = TONEDIV_W + DUR_W;

    state_t                 state, state_nx;
    logic [IDX_W-1:0]       idx_nx;
    logic [DUR_W-1:0]       dur_cnt, dur_nx;
    logic [GAP_W-1:0]       gap_cnt, gap_nx;
    logic [TONEDIV_W-1:0]   tonediv_nx;
    logic                   tone_en_nx;
    logic                   clr, tick, adv, eos;
    logic [ENT_W-1:0]       mem [NOTES];
    logic [ENT_W-1:0]       entry_p1;
    logic [TONEDIV_W-1:0]   ent_div;
    logic [DUR_W-1:0]       ent_dur;

    assign ent_div = entry_p1[ENT_W-1:DUR_W];
    assign ent_dur = entry_p1[DUR_W-1:0];
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .tick  (tick)
    );

    // Read address is the index the FSM is about to hold, so LOAD sees its own entry.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            mem[wr_addr] <= {wr_tonediv, wr_dur};
        end
        entry_p1 <= mem[idx_nx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            note_idx <= '0;
            tonediv  <= '0;
            tone_en  <= 1'b0;
            dur_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_nx;
            note_idx <= idx_nx;
            tonediv  <= tonediv_nx;
            tone_en  <= tone_en_nx;
            dur_cnt  <= dur_nx;
            gap_cnt  <= gap_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        idx_nx     = note_idx;
        tonediv_nx = tonediv;
        tone_en_nx = tone_en;
        dur_nx     = dur_cnt;
        gap_nx     = gap_cnt;
        clr        = 1'b0;
        adv        = 1'b0;
        eos        = 1'b0;

        case (state)
            IDLE: begin
                clr = 1'b1;
                if (start) begin
                    idx_nx   = '0;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                clr = 1'b1;
                if (ent_dur == DUR_W'(END_DUR)) begin
                    eos = 1'b1;
                end else begin
                    tonediv_nx = ent_div;
                    dur_nx     = ent_dur;
                    tone_en_nx = (ent_div != REST_DIV);
                    state_nx   = PLAY;
                end
            end
            PLAY: begin
                if (tick) begin
                    dur_nx = dur_cnt - DUR_W'(1);
                    if (dur_cnt == DUR_W'(1)) begin
                        tone_en_nx = 1'b0;
                        if (GAP_TICKS > 0) begin
                            gap_nx   = GAP_W'(GAP_TICKS);
                            state_nx = GAP;
                        end else begin
                            adv = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    gap_nx = gap_cnt - GAP_W'(1);
                    if (gap_cnt == GAP_W'(1)) begin
                        adv = 1'b1;
                    end
                end
            end
            DONE: begin
                clr        = 1'b1;
                tonediv_nx = '0;
                state_nx   = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (adv) begin
            if (note_idx == IDX_W'(NOTES - 1)) begin
                eos = 1'b1;
            end else begin
                idx_nx   = note_idx + IDX_W'(1);
                state_nx = LOAD;
            end
        end

        // An empty song (entry 0 is the end marker) would spin in LOAD forever if looped.
        if (eos) begin
            if (loop_en && !(state == LOAD && note_idx == '0)) begin
                idx_nx   = '0;
                state_nx = LOAD;
            end else begin
                state_nx = DONE;
            end
        end

        if (stop) begin
            state_nx   = IDLE;
            idx_nx     = note_idx;
            tone_en_nx = 1'b0;
            tonediv_nx = '0;
        end
    end

endmodule

// File: tb/tb_tone_sequencer.sv
// Randomized and directed scoreboard bench for tone_sequencer against a
// table-walking reference model of note/silence/done events.
module tb_tone_sequencer;

    localparam int NOTES = 4;
    localparam int DUR_W = 8;
    localparam int TD    = 4;
    localparam int GAP   = 1;
    localparam int IDX_W = 2;

    logic              clk = 1'b0;
    logic              reset, start, stop, loop_en, wr_en;
    logic [IDX_W-1:0]  wr_addr;
    logic [10:0]       wr_tonediv;
    logic [DUR_W-1:0]  wr_dur;
    logic [10:0]       tonediv;
    logic              tone_en, busy, done;
    logic [IDX_W-1:0]  note_idx;

    tone_sequencer #(
        .NOTES(NOTES), .DUR_W(DUR_W), .TICK_DIV(TD), .GAP_TICKS(GAP)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_tonediv(wr_tonediv), .wr_dur(wr_dur),
        .tonediv(tonediv), .tone_en(tone_en), .busy(busy), .done(done),
        .note_idx(note_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit is_done;
        int div;
        int len;
        int idx;
        int sil;
    } ev_t;

    ev_t exp_q[$];
    int  tbl_div[NOTES];
    int  tbl_dur[NOTES];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: walk the table, emitting audible notes with the silent
    // cycles preceding each one, and the final done event.
    function automatic void model(input bit lp, input int maxn);
        int idx = 0;
        int sil = 1;
        int n = 0;
        int guard = 0;
        ev_t e;
        while (guard < 200) begin
            guard++;
            if (tbl_dur[idx] == 0) begin
                if (lp && idx != 0) begin
                    idx = 0;
                    sil += 1;
                    continue;
                end
                e = '{1'b1, 0, 0, 0, sil};
                exp_q.push_back(e);
                return;
            end
            if (tbl_div[idx] != 0) begin
                e = '{1'b0, tbl_div[idx], tbl_dur[idx] * TD, idx, sil};
                exp_q.push_back(e);
                sil = 0;
                n++;
                if (lp && n >= maxn) return;
            end else begin
                sil += tbl_dur[idx] * TD;
            end
            sil += GAP * TD;
            if (idx == NOTES - 1) begin
                if (!lp) begin
                    e = '{1'b1, 0, 0, 0, sil};
                    exp_q.push_back(e);
                    return;
                end
                idx = 0;
            end else begin
                idx++;
            end
            sil += 1;
        end
    endfunction

    // Monitor: run-length encodes tone_en while busy and pops one event per
    // completed note or done pulse.
    bit prev_busy = 0, prev_ten = 0, done_chk = 0, div_moved = 0;
    int sil_cnt = 0, cur_div = 0, cur_idx = 0, cur_len = 0, cur_sil = 0;

    task automatic pop_check(input bit want_done);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got unexpected %s, expected nothing",
                     want_done ? "done" : "note");
        end else begin
            e = exp_q.pop_front();
            chk("ev_kind", int'(want_done), int'(e.is_done));
            if (want_done) begin
                chk("done_silence", sil_cnt, e.sil);
            end else begin
                chk("note_div", cur_div, e.div);
                chk("note_len", cur_len, e.len);
                chk("note_idx", cur_idx, e.idx);
                chk("note_silence", cur_sil, e.sil);
                chk("note_div_stable", int'(div_moved), 0);
            end
        end
    endtask

    always @(negedge clk) begin
        if (done_chk) begin
            chk("after_done_busy", int'(busy), 0);
            chk("after_done_tonediv", int'(tonediv), 0);
            chk("after_done_pulse", int'(done), 0);
            done_chk = 0;
        end
        if (busy === 1'b1) begin
            if (!prev_busy) sil_cnt = 0;
            if (prev_ten && tone_en !== 1'b1) begin
                pop_check(1'b0);
                sil_cnt = 0;
            end
            if (tone_en === 1'b1) begin
                if (!prev_ten) begin
                    cur_div   = int'(tonediv);
                    cur_idx   = int'(note_idx);
                    cur_len   = 0;
                    cur_sil   = sil_cnt;
                    div_moved = 0;
                end
                cur_len++;
                if (int'(tonediv) != cur_div) div_moved = 1;
            end else if (done === 1'b1) begin
                pop_check(1'b1);
                done_chk = 1;
            end else begin
                sil_cnt++;
            end
        end
        prev_busy = (busy === 1'b1);
        prev_ten  = (busy === 1'b1) && (tone_en === 1'b1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic prog();
        for (int i = 0; i < NOTES; i++) begin
            wr_en      = 1'b1;
            wr_addr    = IDX_W'(i);
            wr_tonediv = 11'(tbl_div[i]);
            wr_dur     = DUR_W'(tbl_dur[i]);
            cyc(1);
        end
        wr_en = 1'b0;
    endtask

    task automatic play(input bit lp, input int maxn);
        model(lp, maxn);
        loop_en = lp;
        start   = 1'b1;
        cyc(1);
        start   = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        while (busy !== 1'b0 && t < budget) begin
            cyc(1);
            t++;
        end
        chk("reach_idle", int'(busy === 1'b0), 1);
        cyc(1);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            cyc(1);
            t++;
        end
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic wait_note(input int idx, input int budget);
        int t = 0;
        while (!(tone_en === 1'b1 && int'(note_idx) == idx) && t < budget) begin
            cyc(1);
            t++;
        end
        chk("note_reached", int'(tone_en === 1'b1 && int'(note_idx) == idx), 1);
    endtask

    task automatic basic_table();
        tbl_div = '{100, 200, 0, 300};
        tbl_dur = '{2, 1, 0, 1};
        prog();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_tonediv = '0; wr_dur = '0;
        cyc(3);
        chk("rst_tonediv", int'(tonediv), 0);
        chk("rst_tone_en", int'(tone_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_note_idx", int'(note_idx), 0);
        reset = 1'b0;
        cyc(1);

        // Basic play ending on the end-of-song marker
        basic_table();
        play(1'b0, 0);
        wait_idle(200);

        // Rest followed by a normal note
        tbl_div = '{0, 150, 0, 0};
        tbl_dur = '{3, 2, 0, 0};
        prog();
        play(1'b0, 0);
        wait_idle(200);

        // Full table looping, then the same table without looping
        tbl_div = '{10, 20, 30, 40};
        tbl_dur = '{1, 1, 1, 1};
        prog();
        play(1'b1, 7);
        wait_drain(400);
        pulse_stop();
        chk("loop_stop_busy", int'(busy), 0);
        exp_q.delete();
        cyc(2);
        play(1'b0, 0);
        wait_idle(200);

        // Empty song with looping must still finish
        tbl_dur[0] = 0;
        prog();
        play(1'b1, 3);
        wait_idle(50);

        // Stop during note 1
        basic_table();
        play(1'b0, 0);
        wait_note(1, 100);
        pulse_stop();
        chk("stop_busy", int'(busy), 0);
        chk("stop_tone_en", int'(tone_en), 0);
        chk("stop_tonediv", int'(tonediv), 0);
        chk("stop_done", int'(done), 0);
        exp_q.delete();
        cyc(2);

        // start and stop together in IDLE
        start = 1'b1; stop = 1'b1;
        cyc(1);
        start = 1'b0; stop = 1'b0;
        chk("start_stop_busy", int'(busy), 0);
        cyc(3);
        chk("start_stop_busy_later", int'(busy), 0);

        // Write and start while busy are ignored
        play(1'b0, 0);
        cyc(3);
        wr_en = 1'b1; wr_addr = '0; wr_tonediv = 11'd999; wr_dur = 8'd3;
        cyc(1);
        wr_en = 1'b0;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("busy_start_idx", int'(note_idx), 0);
        pulse_stop();
        exp_q.delete();
        cyc(2);
        play(1'b0, 0);
        wait_idle(200);

        // Reset during the gap after note 0, then replay
        play(1'b0, 0);
        wait_note(0, 50);
        begin
            int t = 0;
            while (tone_en === 1'b1 && t < 50) begin
                cyc(1);
                t++;
            end
        end
        cyc(1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("gap_rst_tonediv", int'(tonediv), 0);
        chk("gap_rst_tone_en", int'(tone_en), 0);
        chk("gap_rst_busy", int'(busy), 0);
        chk("gap_rst_done", int'(done), 0);
        chk("gap_rst_idx", int'(note_idx), 0);
        exp_q.delete();
        cyc(2);
        play(1'b0, 0);
        wait_idle(200);

        // Randomized songs
        for (int r = 0; r < 12; r++) begin
            bit lp;
            for (int i = 0; i < NOTES; i++) begin
                tbl_dur[i] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 3));
                tbl_div[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 2047));
            end
            lp = 1'($urandom_range(0, 1));
            if (lp) begin
                tbl_dur[0] = int'($urandom_range(1, 3));
                tbl_div[0] = int'($urandom_range(1, 2047));
            end
            prog();
            play(lp, 5);
            if (lp) begin
                wait_drain(1500);
                pulse_stop();
                chk("rand_loop_stop_busy", int'(busy), 0);
                exp_q.delete();
                cyc(2);
            end else begin
                wait_idle(400);
            end
        end

        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
